// File: rtl/rr_priority.sv
// Round-robin priority search: starting at ptr and wrapping modulo PORTS,
// the first asserted request wins. Purely combinational.
module rr_priority #(
  parameter int PORTS = 2,
  parameter int PW    = 1
) (
  input  logic [PORTS-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic [PORTS-1:0] win_oh,
  output logic [PW-1:0]    win_idx
);

  // Walk the ports from ptr upwards with wrap-around and keep the first requester.
  always_comb begin
    logic [PW:0] pos;
    logic        found;
    win_oh  = '0;
    win_idx = '0;
    found   = 1'b0;
    pos     = '0;
    for (int k = 0; k < PORTS; k++) begin
      pos = {1'b0, ptr} + (PW+1)'(k);
      if (pos >= (PW+1)'(PORTS)) begin
        pos = pos - (PW+1)'(PORTS);
      end
      if (!found && req[pos[PW-1:0]]) begin
        found                = 1'b1;
        win_oh[pos[PW-1:0]]  = 1'b1;
        win_idx              = pos[PW-1:0];
      end
    end
  end

endmodule

// File: rtl/simple_ram.sv
// Single-port synchronous RAM with a registered read port, written so that
// block RAM is inferred. Read data only updates on a read enable.
module simple_ram #(
  parameter int SIZE  = 8,
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic            clk,
  input  logic            we,
  input  logic            re,
  input  logic [AW-1:0]   addr,
  input  logic [SIZE-1:0] wdata,
  output logic [SIZE-1:0] rdata
);

  logic [SIZE-1:0] mem [DEPTH];

  // One access per cycle: write the word, or register the addressed word for readout.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between PORTS requesters.
// One transfer per cycle; read data returns one cycle after the grant on a
// shared bus, tagged by a one-hot rd_valid.
//
// Handshake: a requester raises req[p] with we/addr/wdata and holds them until
// it sees gnt[p]; the transfer happens in the cycle where req[p] & gnt[p] is
// true, using the values present in that cycle. Read returns have no
// back-pressure: rd_data must be taken in the cycle rd_valid[p] is high.
module ram_arbiter #(
  parameter  int SIZE  = 8,
  parameter  int DEPTH = 256,
  parameter  int PORTS = 2,
  localparam int AW    = $clog2(DEPTH),
  localparam int PW    = (PORTS > 1) ? $clog2(PORTS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [PORTS-1:0]      req,
  input  logic [PORTS-1:0]      we,
  input  logic [PORTS*AW-1:0]   addr,
  input  logic [PORTS*SIZE-1:0] wdata,
  output logic [PORTS-1:0]      gnt,
  output logic [PORTS-1:0]      rd_valid,
  output logic [SIZE-1:0]       rd_data
);

  logic [PW-1:0]    ptr;
  logic [PORTS-1:0] win_oh;
  logic [PW-1:0]    win_idx;
  logic             xfer;
  logic [AW-1:0]    sel_addr;
  logic             sel_we;
  logic [SIZE-1:0]  sel_wdata;
  logic             in_range;
  logic             ram_we;
  logic             ram_re;
  logic [SIZE-1:0]  ram_rdata;
  logic             oor_q;

  rr_priority #(
    .PORTS (PORTS),
    .PW    (PW)
  ) u_prio (
    .req     (req),
    .ptr     (ptr),
    .win_oh  (win_oh),
    .win_idx (win_idx)
  );

  // Grant is combinational and suppressed immediately while reset is held.
  assign gnt  = rst_n ? win_oh : '0;
  assign xfer = |gnt;

  // Steer the winning port's request onto the RAM.
  assign sel_addr  = addr[win_idx*AW +: AW];
  assign sel_we    = we[win_idx];
  assign sel_wdata = wdata[win_idx*SIZE +: SIZE];

  // Addresses at or beyond DEPTH are accepted but never touch the array.
  assign in_range = ({1'b0, sel_addr} < (AW+1)'(DEPTH));
  assign ram_we   = xfer & sel_we & in_range;
  assign ram_re   = xfer & ~sel_we & in_range;

  simple_ram #(
    .SIZE  (SIZE),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (sel_addr),
    .wdata (sel_wdata),
    .rdata (ram_rdata)
  );

  // Advance the pointer past the winner, and register read-return tag and oor flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr      <= '0;
      rd_valid <= '0;
      oor_q    <= 1'b0;
    end else begin
      if (xfer) begin
        if (win_idx == PW'(PORTS-1)) begin
          ptr <= '0;
        end else begin
          ptr <= win_idx + 1'b1;
        end
      end
      rd_valid <= gnt & {PORTS{~sel_we}};
      oor_q    <= xfer & ~sel_we & ~in_range;
    end
  end

  // Out-of-range reads return zero instead of the (unread) RAM output.
  assign rd_data = oor_q ? '0 : ram_rdata;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: two instances (2 ports / DEPTH 200, 4 ports / DEPTH 256)
// checked every cycle against a behavioural model, plus directed literal checks.
module tb_ram_arbiter;

  localparam int SIZE    = 8;
  localparam int AW      = 8;
  localparam int DEPTH_A = 200;
  localparam int PORTS_A = 2;
  localparam int DEPTH_B = 256;
  localparam int PORTS_B = 4;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [PORTS_A-1:0]      req_a   = '0;
  logic [PORTS_A-1:0]      we_a    = '0;
  logic [PORTS_A*AW-1:0]   addr_a  = '0;
  logic [PORTS_A*SIZE-1:0] wdata_a = '0;
  logic [PORTS_A-1:0]      gnt_a;
  logic [PORTS_A-1:0]      rdv_a;
  logic [SIZE-1:0]         rdd_a;

  logic [PORTS_B-1:0]      req_b   = '0;
  logic [PORTS_B-1:0]      we_b    = '0;
  logic [PORTS_B*AW-1:0]   addr_b  = '0;
  logic [PORTS_B*SIZE-1:0] wdata_b = '0;
  logic [PORTS_B-1:0]      gnt_b;
  logic [PORTS_B-1:0]      rdv_b;
  logic [SIZE-1:0]         rdd_b;

  ram_arbiter #(.SIZE(SIZE), .DEPTH(DEPTH_A), .PORTS(PORTS_A)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .req(req_a), .we(we_a), .addr(addr_a),
    .wdata(wdata_a), .gnt(gnt_a), .rd_valid(rdv_a), .rd_data(rdd_a)
  );

  ram_arbiter #(.SIZE(SIZE), .DEPTH(DEPTH_B), .PORTS(PORTS_B)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .req(req_b), .we(we_b), .addr(addr_b),
    .wdata(wdata_b), .gnt(gnt_b), .rd_valid(rdv_b), .rd_data(rdd_b)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;

  int         ptr_m   [2];
  logic [7:0] mem_m   [2][256];
  bit         known_m [2][256];
  // entry: [12] instance, [11:9] port, [8] data known, [7:0] data
  logic [12:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- model views of the inputs ----------------
  function automatic logic [3:0] req_of(input int i);
    return (i == 0) ? {2'b00, req_a} : req_b;
  endfunction

  function automatic logic [3:0] we_of(input int i);
    return (i == 0) ? {2'b00, we_a} : we_b;
  endfunction

  function automatic logic [7:0] addr_of(input int i, input int p);
    return (i == 0) ? addr_a[p*AW +: AW] : addr_b[p*AW +: AW];
  endfunction

  function automatic logic [7:0] wdata_of(input int i, input int p);
    return (i == 0) ? wdata_a[p*SIZE +: SIZE] : wdata_b[p*SIZE +: SIZE];
  endfunction

  // First requester at or after the pointer, counting modulo the port count.
  function automatic logic [3:0] exp_gnt(input int i);
    logic [3:0] r;
    int np;
    int p;
    r  = req_of(i);
    np = (i == 0) ? PORTS_A : PORTS_B;
    if (!rst_n) return 4'b0000;
    for (int k = 0; k < np; k++) begin
      p = (ptr_m[i] + k) % np;
      if (r[p]) return 4'(1 << p);
    end
    return 4'b0000;
  endfunction

  task automatic check_out(input int i);
    logic [3:0]  g;
    logic [3:0]  v;
    logic [3:0]  ev;
    logic [7:0]  d;
    logic [12:0] e;
    g  = (i == 0) ? {2'b00, gnt_a} : gnt_b;
    v  = (i == 0) ? {2'b00, rdv_a} : rdv_b;
    d  = (i == 0) ? rdd_a : rdd_b;
    ev = 4'b0000;
    e  = '0;
    chk($sformatf("model_gnt%0d", i), 32'(g), 32'(exp_gnt(i)));
    if (exp_q.size() > 0 && exp_q[0][12] == i[0]) begin
      e = exp_q.pop_front();
      if (rst_n) ev = 4'(1 << e[11:9]);
    end
    chk($sformatf("model_rd_valid%0d", i), 32'(v), 32'(ev));
    if (ev != 4'b0000 && e[8]) begin
      chk($sformatf("model_rd_data%0d", i), 32'(d), 32'(e[7:0]));
    end
  endtask

  // Apply what the coming clock edge does: memory write, read return, pointer move.
  task automatic update(input int i);
    logic [3:0] g;
    logic [3:0] wv;
    logic [7:0] a;
    logic [7:0] wd;
    int w;
    int np;
    int dep;
    if (!rst_n) begin
      ptr_m[i] = 0;
      return;
    end
    g = exp_gnt(i);
    if (g == 4'b0000) return;
    np  = (i == 0) ? PORTS_A : PORTS_B;
    dep = (i == 0) ? DEPTH_A : DEPTH_B;
    w = 0;
    for (int p = 0; p < 4; p++) if (g[p]) w = p;
    a  = addr_of(i, w);
    wd = wdata_of(i, w);
    wv = we_of(i);
    if (wv[w]) begin
      if (int'(a) < dep) begin
        mem_m[i][a]   = wd;
        known_m[i][a] = 1'b1;
      end
    end else if (int'(a) >= dep) begin
      exp_q.push_back({i[0], 3'(w), 1'b1, 8'h00});
    end else begin
      exp_q.push_back({i[0], 3'(w), known_m[i][a], mem_m[i][a]});
    end
    ptr_m[i] = (w + 1) % np;
  endtask

  // Compare process: every cycle, both instances, at the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      check_out(0);
      check_out(1);
      update(0);
      update(1);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic [1:0] r, input logic [1:0] w,
                         input logic [7:0] a0, input logic [7:0] a1,
                         input logic [7:0] d0, input logic [7:0] d1);
    req_a   = r;
    we_a    = w;
    addr_a  = {a1, a0};
    wdata_a = {d1, d0};
  endtask

  function automatic logic [7:0] pick_addr(input int i);
    if ($urandom_range(0, 3) == 0) return 8'($urandom_range(0, 255));
    if (i == 0 && $urandom_range(0, 1) == 1) return 8'($urandom_range(190, 209));
    return 8'($urandom_range(0, 15));
  endfunction

  task automatic randomize_inputs();
    for (int p = 0; p < PORTS_A; p++) begin
      req_a[p]               = ($urandom_range(0, 99) < 70);
      we_a[p]                = 1'($urandom_range(0, 1));
      addr_a[p*AW +: AW]     = pick_addr(0);
      wdata_a[p*SIZE +: SIZE] = 8'($urandom_range(0, 255));
    end
    for (int p = 0; p < PORTS_B; p++) begin
      req_b[p]               = ($urandom_range(0, 99) < 60);
      we_b[p]                = 1'($urandom_range(0, 1));
      addr_b[p*AW +: AW]     = pick_addr(1);
      wdata_b[p*SIZE +: SIZE] = 8'($urandom_range(0, 255));
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    repeat (3) step();
    @(negedge clk);
    chk("reset_gnt_a", 32'(gnt_a), 32'h0);
    chk("reset_rdv_a", 32'(rdv_a), 32'h0);
    chk("reset_gnt_b", 32'(gnt_b), 32'h0);
    chk("reset_rdv_b", 32'(rdv_b), 32'h0);
    step();
    rst_n = 1'b1;

    // port0 writes A5 to addr 3, port1 reads it back
    step(); drive_a(2'b01, 2'b01, 8'd3, 8'd0, 8'hA5, 8'h00);
    @(negedge clk); chk("wr_gnt", 32'(gnt_a), 32'h1);
    step(); drive_a(2'b10, 2'b00, 8'd0, 8'd3, 8'h00, 8'h00);
    @(negedge clk); chk("rd_gnt", 32'(gnt_a), 32'h2);
    chk("wr_no_rdv", 32'(rdv_a), 32'h0);
    step(); drive_a(2'b00, 2'b00, 8'd0, 8'd0, 8'h00, 8'h00);
    @(negedge clk); chk("rd_rdv", 32'(rdv_a), 32'h2);
    chk("rd_data_a5", 32'(rdd_a), 32'hA5);

    // both ports read continuously: grants alternate
    for (int c = 0; c < 6; c++) begin
      step(); drive_a(2'b11, 2'b00, 8'd3, 8'd3, 8'h00, 8'h00);
      @(negedge clk);
      chk("alt_gnt", 32'(gnt_a), (c % 2 == 1) ? 32'h2 : 32'h1);
      if (c > 0) chk("alt_rdv", 32'(rdv_a), (c % 2 == 1) ? 32'h1 : 32'h2);
    end
    step(); drive_a(2'b00, 2'b00, 8'd0, 8'd0, 8'h00, 8'h00);
    @(negedge clk); chk("alt_last_rdv", 32'(rdv_a), 32'h2);

    // write then immediate read of the same address
    step(); drive_a(2'b01, 2'b01, 8'd7, 8'd0, 8'h11, 8'h00);
    @(negedge clk); chk("b2b_wr_gnt", 32'(gnt_a), 32'h1);
    step(); drive_a(2'b10, 2'b00, 8'd0, 8'd7, 8'h00, 8'h00);
    @(negedge clk); chk("b2b_rd_gnt", 32'(gnt_a), 32'h2);
    step(); drive_a(2'b00, 2'b00, 8'd0, 8'd0, 8'h00, 8'h00);
    @(negedge clk); chk("b2b_rdv", 32'(rdv_a), 32'h2);
    chk("b2b_data", 32'(rdd_a), 32'h11);

    // out-of-range handling on the DEPTH=200 instance
    step(); drive_a(2'b01, 2'b01, 8'd199, 8'd0, 8'h3C, 8'h00);
    @(negedge clk); chk("oor_prep_gnt", 32'(gnt_a), 32'h1);
    step(); drive_a(2'b01, 2'b01, 8'd250, 8'd0, 8'hFF, 8'h00);
    @(negedge clk); chk("oor_wr_gnt", 32'(gnt_a), 32'h1);
    step(); drive_a(2'b10, 2'b00, 8'd0, 8'd250, 8'h00, 8'h00);
    @(negedge clk); chk("oor_rd_gnt", 32'(gnt_a), 32'h2);
    step(); drive_a(2'b01, 2'b00, 8'd199, 8'd0, 8'h00, 8'h00);
    @(negedge clk); chk("oor_rdv", 32'(rdv_a), 32'h2);
    chk("oor_data_zero", 32'(rdd_a), 32'h0);
    chk("last_rd_gnt", 32'(gnt_a), 32'h1);
    step(); drive_a(2'b00, 2'b00, 8'd0, 8'd0, 8'h00, 8'h00);
    @(negedge clk); chk("last_rdv", 32'(rdv_a), 32'h1);
    chk("last_data", 32'(rdd_a), 32'h3C);

    // reset right after a read grant
    step(); drive_a(2'b01, 2'b00, 8'd3, 8'd0, 8'h00, 8'h00);
    @(negedge clk); chk("pre_rst_gnt", 32'(gnt_a), 32'h1);
    step(); rst_n = 1'b0; drive_a(2'b11, 2'b00, 8'd3, 8'd3, 8'h00, 8'h00);
    @(negedge clk); chk("rst_gnt", 32'(gnt_a), 32'h0);
    chk("rst_rdv", 32'(rdv_a), 32'h0);
    step();
    @(negedge clk); chk("rst_gnt2", 32'(gnt_a), 32'h0);
    chk("rst_rdv2", 32'(rdv_a), 32'h0);
    step(); rst_n = 1'b1;
    @(negedge clk); chk("post_rst_gnt", 32'(gnt_a), 32'h1);
    step();
    @(negedge clk); chk("post_rst_gnt2", 32'(gnt_a), 32'h2);
    chk("post_rst_data", 32'(rdd_a), 32'hA5);
    step(); drive_a(2'b00, 2'b00, 8'd0, 8'd0, 8'h00, 8'h00);

    // 4-port instance, only ports 1 and 3 requesting
    for (int c = 0; c < 4; c++) begin
      step();
      req_b  = 4'b1010;
      we_b   = 4'b0000;
      addr_b = {4{8'd5}};
      @(negedge clk);
      chk("p4_gnt", 32'(gnt_b), (c % 2 == 1) ? 32'h8 : 32'h2);
    end
    step(); req_b = 4'b0000;

    // randomized traffic on both instances with occasional reset pulses
    for (int n = 0; n < 3000; n++) begin
      step();
      rst_n = ($urandom_range(0, 299) != 0);
      randomize_inputs();
    end
    step();
    rst_n = 1'b1;
    drive_a(2'b00, 2'b00, 8'd0, 8'd0, 8'h00, 8'h00);
    req_b = 4'b0000;
    repeat (3) step();
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
